// File: rtl/aes_pkg.sv
// Shared AES-256 key-schedule definitions: sizes, FSM states, round-key type,
// S-box (GF(2^8) inverse plus affine map), SubWord and Rcon helpers.
package aes_pkg;

    localparam int AES256_NUM_RK    = 15;
    localparam int AES256_EXP_STEPS = 7;

    typedef logic [127:0] round_key_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } state_t;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse computed as x^254 (254 = 8'b1111_1110), which also maps 0 to 0.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] base;
        r    = 8'h01;
        base = x;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) r = gf_mul(r, base);
            base = gf_mul(base, base);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rcon(input logic [2:0] s);
        logic [7:0] b;
        b = 8'h01 << s;
        return {b, 24'h000000};
    endfunction

endpackage

// File: rtl/key_expansion_256.sv
// One AES-256 key-expansion step: eight input words w0..w7 produce the next
// eight words w8..w15 using the supplied round constant word.
module key_expansion_256
    import aes_pkg::*;
(
    input  logic [255:0] i_work,
    input  logic [31:0]  i_rcon,
    output logic [255:0] o_next
);

    logic [31:0] w_w [8];
    logic [31:0] w_n0, w_n1, w_n2, w_n3, w_n4, w_n5, w_n6, w_n7;

    always_comb begin
        for (int k = 0; k < 8; k++) w_w[k] = i_work[255 - 32*k -: 32];
    end

    assign w_n0 = w_w[0] ^ sub_word({w_w[7][23:0], w_w[7][31:24]}) ^ i_rcon;
    assign w_n1 = w_w[1] ^ w_n0;
    assign w_n2 = w_w[2] ^ w_n1;
    assign w_n3 = w_w[3] ^ w_n2;
    // The AES-256 mid-block word gets SubWord without rotation or Rcon.
    assign w_n4 = w_w[4] ^ sub_word(w_n3);
    assign w_n5 = w_w[5] ^ w_n4;
    assign w_n6 = w_w[6] ^ w_n5;
    assign w_n7 = w_w[7] ^ w_n6;

    assign o_next = {w_n0, w_n1, w_n2, w_n3, w_n4, w_n5, w_n6, w_n7};

endmodule

// File: rtl/key_schedule_buffer256.sv
// AES-256 round-key generator/store: one expansion step per clock, 15 keys held,
// registered read port (reverse order by default). Option macro: AES_RK_ZEROIZE_EN.
module key_schedule_buffer256
    import aes_pkg::*;
#(
    parameter int KEY_W     = 256,
    parameter int RK_W      = 128,
    parameter int NUM_RK    = AES256_NUM_RK,
    parameter int REV_ORDER = 1
) (
    input  logic             clk,
    input  logic             rst,
`ifdef AES_RK_ZEROIZE_EN
    input  logic             zeroize,
`endif
    input  logic [KEY_W-1:0] key_in,
    input  logic             key_valid,
    output logic             key_ready,
    output logic             busy,
    output logic             keys_ready,
    input  logic             rd_en,
    input  logic [3:0]       rd_idx,
    output logic [RK_W-1:0]  rk_out,
    output logic             rk_valid
);

    state_t           r_state;
    logic [2:0]       r_step;
    logic [KEY_W-1:0] r_work;
    logic [RK_W-1:0]  r_rk_mem [NUM_RK];
    logic [RK_W-1:0]  r_rk_out;
    logic             r_rk_valid;

    logic [KEY_W-1:0] w_nxt;
    logic [31:0]      w_rcon;
    round_key_t       w_rk_hi;
    round_key_t       w_rk_lo;
    logic             w_clear;
    logic             w_last;
    logic             w_rd_acc;
    logic [3:0]       w_rd_addr;
    logic [3:0]       w_wr_hi;
    logic [3:0]       w_wr_lo;

`ifdef AES_RK_ZEROIZE_EN
    assign w_clear = rst || zeroize;
`else
    assign w_clear = rst;
`endif

    assign w_rcon  = rcon(r_step);
    assign w_rk_hi = w_nxt[KEY_W-1:RK_W];
    assign w_rk_lo = w_nxt[RK_W-1:0];
    assign w_last  = (r_step == 3'(AES256_EXP_STEPS - 1));
    assign w_wr_hi = {r_step, 1'b0} + 4'd2;
    assign w_wr_lo = {r_step, 1'b0} + 4'd3;

    assign w_rd_acc  = rd_en && (r_state == READY) && (rd_idx <= 4'(NUM_RK - 1));
    assign w_rd_addr = (REV_ORDER != 0) ? 4'(NUM_RK - 1) - rd_idx : rd_idx;

    key_expansion_256 u_kexp (
        .i_work (r_work),
        .i_rcon (w_rcon),
        .o_next (w_nxt)
    );

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_state    <= IDLE;
            r_step     <= 3'd0;
            r_work     <= '0;
            r_rk_out   <= '0;
            r_rk_valid <= 1'b0;
            for (int i = 0; i < NUM_RK; i++) r_rk_mem[i] <= '0;
        end else begin
            // Read samples storage before this edge's writes, so a read alongside
            // a reload still returns the previous key's material.
            r_rk_valid <= w_rd_acc;
            r_rk_out   <= w_rd_acc ? r_rk_mem[w_rd_addr] : '0;
            case (r_state)
                EXPAND: begin
                    r_rk_mem[w_wr_hi] <= w_rk_hi;
                    if (!w_last) r_rk_mem[w_wr_lo] <= w_rk_lo;
                    r_work <= w_nxt;
                    if (w_last) begin
                        r_step  <= 3'd0;
                        r_state <= READY;
                    end else begin
                        r_step <= r_step + 3'd1;
                    end
                end
                default: begin
                    if (key_valid) begin
                        r_rk_mem[0] <= key_in[KEY_W-1:RK_W];
                        r_rk_mem[1] <= key_in[RK_W-1:0];
                        r_work      <= key_in;
                        r_step      <= 3'd0;
                        r_state     <= EXPAND;
                    end
                end
            endcase
        end
    end

    assign key_ready  = (r_state != EXPAND);
    assign busy       = (r_state == EXPAND);
    assign keys_ready = (r_state == READY);
    assign rk_out     = r_rk_out;
    assign rk_valid   = r_rk_valid;

endmodule

// File: tb/tb_key_schedule_buffer256.sv
// Bench for key_schedule_buffer256: reverse- and forward-order instances side by side,
// read results checked against a cycle-stamped expectation queue.
module tb_key_schedule_buffer256;

    localparam logic [255:0] K1 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] K2 = 256'hdeadbeef0badf00dcafebabe123456789abcdef0fedcba9876543210a5a5c3c3;
    localparam logic [255:0] K3 = 256'h1111111122222222333333334444444455555555666666667777777788888888;
    localparam logic [127:0] RK0  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] RK1  = 128'h101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] RK2  = 128'ha573c29fa176c498a97fce93a572c09c;
    localparam logic [127:0] RK13 = 128'h4e5a6699a9f24fe07e572baacdf8cdea;
    localparam logic [127:0] RK14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;
    localparam logic [127:0] Z    = 128'h0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, key_valid, rd_en;
    logic [255:0] key_in;
    logic [3:0]   rd_idx;
`ifdef AES_RK_ZEROIZE_EN
    logic         zeroize;
`endif
    logic         key_ready, busy, keys_ready, rk_valid;
    logic [127:0] rk_out;
    logic         key_ready_f, busy_f, keys_ready_f, rk_valid_f;
    logic [127:0] rk_out_f;

    key_schedule_buffer256 #(.REV_ORDER(1)) dut (
        .clk(clk), .rst(rst),
`ifdef AES_RK_ZEROIZE_EN
        .zeroize(zeroize),
`endif
        .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready),
        .busy(busy), .keys_ready(keys_ready), .rd_en(rd_en), .rd_idx(rd_idx),
        .rk_out(rk_out), .rk_valid(rk_valid)
    );

    key_schedule_buffer256 #(.REV_ORDER(0)) dut_f (
        .clk(clk), .rst(rst),
`ifdef AES_RK_ZEROIZE_EN
        .zeroize(zeroize),
`endif
        .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready_f),
        .busy(busy_f), .keys_ready(keys_ready_f), .rd_en(rd_en), .rd_idx(rd_idx),
        .rk_out(rk_out_f), .rk_valid(rk_valid_f)
    );

    typedef struct {
        int         stamp;
        logic       vld;
        bit         chk_r;
        logic [127:0] rk_r;
        bit         chk_f;
        logic [127:0] rk_f;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard consumer: each stamped expectation is compared in the cycle it
    // becomes visible; any other cycle must show no read result.
    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() != 0 && sb[0].stamp == cyc) begin
                m_e = sb.pop_front();
                total++;
                if (rk_valid !== m_e.vld || rk_valid_f !== m_e.vld) begin
                    bad++;
                    $display("FAIL rk_valid @%0d: got rev=%b fwd=%b want %b", cyc, rk_valid, rk_valid_f, m_e.vld);
                end
                if (m_e.chk_r) begin
                    total++;
                    if (rk_out !== m_e.rk_r) begin
                        bad++;
                        $display("FAIL rk_out_rev @%0d: got %h want %h", cyc, rk_out, m_e.rk_r);
                    end
                end
                if (m_e.chk_f) begin
                    total++;
                    if (rk_out_f !== m_e.rk_f) begin
                        bad++;
                        $display("FAIL rk_out_fwd @%0d: got %h want %h", cyc, rk_out_f, m_e.rk_f);
                    end
                end
            end else begin
                total++;
                if (rk_valid !== 1'b0 || rk_valid_f !== 1'b0 || rk_out !== Z || rk_out_f !== Z) begin
                    bad++;
                    $display("FAIL idle_read @%0d: got v=%b/%b out=%h/%h want 0", cyc, rk_valid, rk_valid_f, rk_out, rk_out_f);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [3:0] idx, input logic vld,
                      input bit cr, input logic [127:0] rr,
                      input bit cf, input logic [127:0] rf);
        exp_t e;
        e.stamp = cyc + 1;
        e.vld   = vld;
        e.chk_r = cr;
        e.rk_r  = rr;
        e.chk_f = cf;
        e.rk_f  = rf;
        sb.push_back(e);
        rd_en  = 1'b1;
        rd_idx = idx;
        tick();
        rd_en  = 1'b0;
    endtask

    task automatic expand_check(input logic [255:0] k, input string tag);
        key_in    = k;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            total++;
            if (busy !== 1'b1 || keys_ready !== 1'b0 || key_ready !== 1'b0 || busy_f !== 1'b1) begin
                bad++;
                $display("FAIL %s_busy[%0d]: got busy=%b kr=%b krdy=%b want 1/0/0", tag, i, busy, keys_ready, key_ready);
            end
            tick();
        end
        total++;
        if (busy !== 1'b0 || keys_ready !== 1'b1 || key_ready !== 1'b1 || keys_ready_f !== 1'b1) begin
            bad++;
            $display("FAIL %s_done: got busy=%b kr=%b krdy=%b want 0/1/1", tag, busy, keys_ready, key_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; key_valid = 1'b0; rd_en = 1'b0; rd_idx = 4'd0; key_in = '0;
`ifdef AES_RK_ZEROIZE_EN
        zeroize = 1'b0;
`endif
        tick();
        tick();
        total++;
        if (busy !== 1'b0 || keys_ready !== 1'b0 || key_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ctrl: got busy=%b kr=%b krdy=%b want 0/0/1", busy, keys_ready, key_ready);
        end
        total++;
        if (rk_valid !== 1'b0 || rk_out !== Z || rk_valid_f !== 1'b0 || rk_out_f !== Z) begin
            bad++;
            $display("FAIL reset_rd: got v=%b out=%h want 0", rk_valid, rk_out);
        end
        rst = 1'b0;
        mon_en = 1'b1;
        tick();
    endtask

    task automatic test_vector1();
        expand_check(K1, "k1");
        rd(4'd14, 1'b1, 1'b1, RK0,  1'b1, RK14);
        rd(4'd0,  1'b1, 1'b1, RK14, 1'b1, RK0);
        rd(4'd1,  1'b1, 1'b1, RK13, 1'b1, RK1);
        rd(4'd13, 1'b1, 1'b1, RK1,  1'b1, RK13);
        rd(4'd2,  1'b1, 1'b0, Z,    1'b1, RK2);
        rd(4'd12, 1'b1, 1'b1, RK2,  1'b0, Z);
        rd(4'd15, 1'b0, 1'b1, Z,    1'b1, Z);
        tick();
    endtask

    task automatic test_ignore_during_expand();
        key_in    = K2;
        key_valid = 1'b1;
        tick();
        key_in = K3;
        for (int i = 0; i < 7; i++) begin
            total++;
            if (key_ready !== 1'b0 || busy !== 1'b1 || keys_ready !== 1'b0) begin
                bad++;
                $display("FAIL hold_key[%0d]: got krdy=%b busy=%b kr=%b want 0/1/0", i, key_ready, busy, keys_ready);
            end
            tick();
        end
        key_valid = 1'b0;
        total++;
        if (keys_ready !== 1'b1) begin
            bad++;
            $display("FAIL reload_ready: got %b want 1", keys_ready);
        end
        rd(4'd14, 1'b1, 1'b1, K2[255:128], 1'b0, Z);
        rd(4'd13, 1'b1, 1'b1, K2[127:0],   1'b0, Z);
        rd(4'd0,  1'b1, 1'b0, Z,           1'b1, K2[255:128]);
        rd(4'd1,  1'b1, 1'b0, Z,           1'b1, K2[127:0]);
        tick();
    endtask

    task automatic test_read_during_reload();
        key_in    = K1;
        key_valid = 1'b1;
        rd(4'd0, 1'b1, 1'b0, Z, 1'b1, K2[255:128]);
        key_valid = 1'b0;
        rd(4'd14, 1'b0, 1'b1, Z, 1'b1, Z);
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (keys_ready !== 1'b0) begin
                bad++;
                $display("FAIL reload_low[%0d]: got %b want 0", i, keys_ready);
            end
        end
        tick();
        total++;
        if (keys_ready !== 1'b1) begin
            bad++;
            $display("FAIL reload_high: got %b want 1", keys_ready);
        end
        rd(4'd14, 1'b1, 1'b1, RK0,  1'b1, RK14);
        rd(4'd0,  1'b1, 1'b1, RK14, 1'b1, RK0);
        tick();
    endtask

    task automatic test_rst_mid_expand();
        key_in    = K2;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (busy !== 1'b0 || keys_ready !== 1'b0 || key_ready !== 1'b1 || rk_valid !== 1'b0 || rk_out !== Z) begin
            bad++;
            $display("FAIL rst_mid: got busy=%b kr=%b krdy=%b v=%b want 0/0/1/0", busy, keys_ready, key_ready, rk_valid);
        end
        expand_check(K1, "after_rst");
        rd(4'd0,  1'b1, 1'b1, RK14, 1'b1, RK0);
        rd(4'd14, 1'b1, 1'b1, RK0,  1'b1, RK14);
        tick();
    endtask

`ifdef AES_RK_ZEROIZE_EN
    task automatic test_zeroize();
        zeroize = 1'b1;
        rd(4'd14, 1'b0, 1'b1, Z, 1'b1, Z);
        zeroize = 1'b0;
        total++;
        if (keys_ready !== 1'b0 || busy !== 1'b0 || key_ready !== 1'b1) begin
            bad++;
            $display("FAIL zeroize_state: got kr=%b busy=%b krdy=%b want 0/0/1", keys_ready, busy, key_ready);
        end
        zeroize   = 1'b1;
        key_valid = 1'b1;
        key_in    = K1;
        tick();
        zeroize   = 1'b0;
        key_valid = 1'b0;
        total++;
        if (busy !== 1'b0 || keys_ready !== 1'b0) begin
            bad++;
            $display("FAIL zeroize_key: got busy=%b kr=%b want 0/0", busy, keys_ready);
        end
        expand_check(K1, "rekey");
        rd(4'd14, 1'b1, 1'b1, RK0,  1'b1, RK14);
        rd(4'd0,  1'b1, 1'b1, RK14, 1'b1, RK0);
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_vector1();
        test_ignore_during_expand();
        test_read_during_reload();
        test_rst_mid_expand();
`ifdef AES_RK_ZEROIZE_EN
        test_zeroize();
`endif
        tick();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish before 200000");
        $fatal(1);
    end

endmodule
